truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/sweeper_pkg.sv | 22 ++
 rtl/truth_table_sweeper_if.sv | 26 ++
 rtl/sweep_counter.sv | 59 +++++
 rtl/truth_table_sweeper.sv | 108 ++++++++++
 4 files changed

// File: rtl/sweeper_pkg.sv
// Shared types and sizes for the truth-table sweeper: FSM states, vector
// count and the widths derived from it.
package sweeper_pkg;

  localparam int NUM_VECTORS = 32;
  localparam int VEC_W       = 5;
  localparam int CNT_W       = $clog2(NUM_VECTORS + 1);
  localparam int SETTLE_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  // Packs a vector index into the single-bit A..E drive lines, A = MSB.
  function automatic logic [VEC_W-1:0] vec_of(input logic [VEC_W-1:0] idx);
    return idx;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, golden-table, stimulus and result signals between the sweeper and
// its user. "expect" is a reserved word in SystemVerilog, hence expect_tbl.
interface truth_table_sweeper_if;
  import sweeper_pkg::*;

  logic                   start;
  logic [NUM_VECTORS-1:0] expect_tbl;
  logic                   Y;
  logic                   A, B, C, D, E;
  logic                   busy;
  logic                   done;
  logic [NUM_VECTORS-1:0] result;
  logic [CNT_W-1:0]       mismatch_count;
  logic [VEC_W-1:0]       first_mismatch;

  modport master (
    output start, expect_tbl, Y,
    input  A, B, C, D, E, busy, done, result, mismatch_count, first_mismatch
  );

  modport slave (
    input  start, expect_tbl, Y,
    output A, B, C, D, E, busy, done, result, mismatch_count, first_mismatch
  );

endinterface

// File: rtl/sweep_counter.sv
// Vector index and settle-cycle counter for the sweeper. The index stops at
// the last vector; it never wraps inside a sweep.
module sweep_counter
  import sweeper_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             settle_en,
  input  logic             advance,
  output logic [VEC_W-1:0] index,
  output logic             settle_done,
  output logic             last
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0]    LAST_INDEX  = VEC_W'(NUM_VECTORS - 1);

  logic [VEC_W-1:0]    index_q, index_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;

  assign index       = index_q;
  assign settle_done = (settle_q == SETTLE_LAST);
  assign last        = (index_q == LAST_INDEX);

  // NOTE: every variable gets its hold value first so no path through the
  // block leaves it unassigned, which would infer a latch.
  always_comb begin
    index_d  = index_q;
    settle_d = settle_q;
    if (clear) begin
      index_d  = '0;
      settle_d = '0;
    end else begin
      if (settle_en) begin
        settle_d = settle_done ? '0 : settle_q + 1'b1;
      end
      if (advance && !last) begin
        index_d  = index_q + 1'b1;
        settle_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q  <= '0;
      settle_q <= '0;
    end else begin
      index_q  <= index_d;
      settle_q <= settle_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all 32 input vectors of a 5-input combinational function, samples Y
// after a settle delay, and compares the captured table with a golden one.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_sweeper_if.slave  bus
);

  state_e                 state_q, state_d;
  logic [NUM_VECTORS-1:0] expect_q, expect_d;
  logic [NUM_VECTORS-1:0] result_q, result_d;
  logic [CNT_W-1:0]       mm_cnt_q, mm_cnt_d;
  logic [VEC_W-1:0]       first_mm_q, first_mm_d;

  logic             cnt_clear;
  logic             cnt_settle_en;
  logic             cnt_advance;
  logic [VEC_W-1:0] index;
  logic             settle_done;
  logic             last;

  sweep_counter #(
    .SETTLE (SETTLE)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       (cnt_clear),
    .settle_en   (cnt_settle_en),
    .advance     (cnt_advance),
    .index       (index),
    .settle_done (settle_done),
    .last        (last)
  );

  // A..E come straight from the index register, so they never glitch; the
  // index is 0 in IDLE and parks at the last vector in DONE.
  assign {bus.A, bus.B, bus.C, bus.D, bus.E} = vec_of(index);

  assign bus.busy           = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done           = (state_q == DONE);
  assign bus.result         = result_q;
  assign bus.mismatch_count = mm_cnt_q;
  assign bus.first_mismatch = first_mm_q;

  always_comb begin
    state_d       = state_q;
    expect_d      = expect_q;
    result_d      = result_q;
    mm_cnt_d      = mm_cnt_q;
    first_mm_d    = first_mm_q;
    cnt_clear     = 1'b0;
    cnt_settle_en = 1'b0;
    cnt_advance   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = DRIVE;
          expect_d   = bus.expect_tbl;
          result_d   = '0;
          mm_cnt_d   = '0;
          first_mm_d = '0;
          cnt_clear  = 1'b1;
        end
      end
      DRIVE: begin
        cnt_settle_en = 1'b1;
        if (settle_done) state_d = SAMPLE;
      end
      SAMPLE: begin
        result_d[index] = bus.Y;
        if (bus.Y != expect_q[index]) begin
          mm_cnt_d = mm_cnt_q + 1'b1;
          // A zero count means this is the first mismatch of the sweep.
          if (mm_cnt_q == '0) first_mm_d = index;
        end
        if (last) begin
          state_d = DONE;
        end else begin
          state_d     = DRIVE;
          cnt_advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      expect_q   <= '0;
      result_q   <= '0;
      mm_cnt_q   <= '0;
      first_mm_q <= '0;
    end else begin
      state_q    <= state_d;
      expect_q   <= expect_d;
      result_q   <= result_d;
      mm_cnt_q   <= mm_cnt_d;
      first_mm_q <= first_mm_d;
    end
  end

endmodule
